// File: rtl/neokeon_rot_pkg.sv
// Shared definitions for the Neokeon word-rotation pipeline: default geometry,
// direction encoding and a rotate-by-constant helper for the round logic.
package neokeon_rot_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 4;
    localparam int DEF_SHW   = $clog2(DEF_WIDTH);

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    // A right rotation by n is the left rotation by the two's complement of n.
    function automatic logic [DEF_WIDTH-1:0] rot_word(
        input logic [DEF_WIDTH-1:0] w,
        input logic                 dir,
        input logic [DEF_SHW-1:0]   shift
    );
        logic [2*DEF_WIDTH-1:0] dbl;
        logic [DEF_SHW-1:0]     lsh;
        lsh = (dir == ROT_RIGHT) ? (~shift + 1'b1) : shift;
        dbl = {w, w} << lsh;
        return dbl[2*DEF_WIDTH-1 -: DEF_WIDTH];
    endfunction

endpackage

// File: rtl/neokeon_rot_stage.sv
// One pipeline stage: conditionally rotates every lane by 2^STAGE and
// registers the result together with the amount/direction for later stages.
module neokeon_rot_stage
    import neokeon_rot_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int STAGE = 0,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prev_valid,
    input  logic [LANES*WIDTH-1:0] prev_data,
    input  logic [LANES*SHW-1:0]   prev_amount,
    input  logic [LANES-1:0]       prev_dir,
    input  logic                   next_ready,
    output logic                   valid,
    output logic [LANES*WIDTH-1:0] data,
    output logic [LANES*SHW-1:0]   amount,
    output logic [LANES-1:0]       dir,
    output logic                   ready
);

    localparam int SH = 1 << STAGE;

    logic [LANES*WIDTH-1:0] rot;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w);
        return {w[WIDTH-SH-1:0], w[WIDTH-1:WIDTH-SH]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] w);
        return {w[SH-1:0], w[WIDTH-1:SH]};
    endfunction

    // A stage can take a new beat when empty or when its content moves on.
    assign ready = !valid || next_ready;

    // Per-lane conditional rotation selected by amount bit STAGE.
    always_comb begin
        rot = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!prev_amount[i*SHW + STAGE]) begin
                rot[i*WIDTH +: WIDTH] = prev_data[i*WIDTH +: WIDTH];
            end else if (prev_dir[i] == ROT_RIGHT) begin
                rot[i*WIDTH +: WIDTH] = rotr(prev_data[i*WIDTH +: WIDTH]);
            end else begin
                rot[i*WIDTH +: WIDTH] = rotl(prev_data[i*WIDTH +: WIDTH]);
            end
        end
    end

    // Stage registers; payload only updates for real beats, never for bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            data   <= '0;
            amount <= '0;
            dir    <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data   <= rot;
                amount <= prev_amount;
                dir    <= prev_dir;
            end
        end
    end

endmodule

// File: rtl/neokeon_rot_pipe.sv
// Pipelined multi-lane rotator: SHW stages, each rotating by a power of two,
// chained with a combinational ready path so a full pipeline keeps streaming.
module neokeon_rot_pipe
    import neokeon_rot_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic                   inClk,
    input  logic                   inRst,
    input  logic                   inValid,
    output logic                   outputUpReady,
    input  logic [LANES*WIDTH-1:0] inDataWord,
    input  logic [LANES*SHW-1:0]   inAmount,
    input  logic [LANES-1:0]       inDir,
    output logic                   outputValid,
    input  logic                   inDownReady,
    output logic [LANES*WIDTH-1:0] outputData
);

    logic [SHW:0]                  valid_s;
    logic [SHW:0]                  ready_s;
    logic [SHW:0][LANES*WIDTH-1:0] data_s;
    logic [SHW:0][LANES*SHW-1:0]   amount_s;
    logic [SHW:0][LANES-1:0]       dir_s;
    logic                          unused_tail;

    assign valid_s[0]    = inValid;
    assign data_s[0]     = inDataWord;
    assign amount_s[0]   = inAmount;
    assign dir_s[0]      = inDir;
    assign ready_s[SHW]  = inDownReady;
    assign outputUpReady = ready_s[0];
    assign outputValid   = valid_s[SHW];
    assign outputData    = data_s[SHW];

    // The last stage's amount/direction copies have no consumer.
    assign unused_tail = ^{amount_s[SHW], dir_s[SHW]};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        neokeon_rot_stage #(
            .WIDTH (WIDTH),
            .LANES (LANES),
            .STAGE (k)
        ) u_stage (
            .clk         (inClk),
            .rst         (inRst),
            .prev_valid  (valid_s[k]),
            .prev_data   (data_s[k]),
            .prev_amount (amount_s[k]),
            .prev_dir    (dir_s[k]),
            .next_ready  (ready_s[k+1]),
            .valid       (valid_s[k+1]),
            .data        (data_s[k+1]),
            .amount      (amount_s[k+1]),
            .dir         (dir_s[k+1]),
            .ready       (ready_s[k])
        );
    end

endmodule

// File: tb/tb_neokeon_rot_pipe.sv
// Scoreboard bench for neokeon_rot_pipe: random and directed beats checked
// against a plain-arithmetic rotation model, plus flow-control and reset cases.
module tb_neokeon_rot_pipe;

    localparam int W = 32;
    localparam int L = 4;
    localparam int S = 5;

    logic           inClk = 1'b0;
    logic           inRst;
    logic           inValid;
    logic           outputUpReady;
    logic [L*W-1:0] inDataWord;
    logic [L*S-1:0] inAmount;
    logic [L-1:0]   inDir;
    logic           outputValid;
    logic           inDownReady;
    logic [L*W-1:0] outputData;

    logic       s_valid, s_up_ready, s_out_valid, s_down_ready;
    logic [7:0] s_data, s_out_data;
    logic [2:0] s_amount;
    logic [0:0] s_dir;

    int checks = 0;
    int failures = 0;
    int pop_count = 0;
    int run_len = 0;
    int max_run = 0;
    logic [L*W-1:0] exp_q[$];

    neokeon_rot_pipe #(.WIDTH(W), .LANES(L)) dut (
        .inClk(inClk), .inRst(inRst), .inValid(inValid), .outputUpReady(outputUpReady),
        .inDataWord(inDataWord), .inAmount(inAmount), .inDir(inDir),
        .outputValid(outputValid), .inDownReady(inDownReady), .outputData(outputData)
    );

    neokeon_rot_pipe #(.WIDTH(8), .LANES(1)) dut_small (
        .inClk(inClk), .inRst(inRst), .inValid(s_valid), .outputUpReady(s_up_ready),
        .inDataWord(s_data), .inAmount(s_amount), .inDir(s_dir),
        .outputValid(s_out_valid), .inDownReady(s_down_ready), .outputData(s_out_data)
    );

    always #5 inClk = ~inClk;

    function automatic logic [31:0] ref_rot(input logic [31:0] w, input int n, input bit right);
        int k;
        logic [63:0] t;
        k = right ? (32 - n) % 32 : n;
        t = {w, w} >> (32 - k);
        return t[31:0];
    endfunction

    function automatic logic [L*W-1:0] model(input logic [L*W-1:0] d, input logic [L*S-1:0] a,
                                            input logic [L-1:0] r);
        logic [L*W-1:0] res;
        for (int i = 0; i < L; i++)
            res[i*W +: W] = ref_rot(d[i*W +: W], int'(a[i*S +: S]), r[i]);
        return res;
    endfunction

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [L*S-1:0] rnd_amt();
        logic [L*S-1:0] a;
        for (int i = 0; i < L; i++) a[i*S +: S] = 5'($urandom_range(0, 31));
        return a;
    endfunction

    function automatic logic [L*W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: records accepted inputs as expectations and checks every output transfer.
    initial begin
        logic           prev_stall;
        logic [L*W-1:0] held;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge inClk);
            if (inRst) begin
                prev_stall = 1'b0;
                run_len = 0;
            end else begin
                if (inValid && outputUpReady)
                    exp_q.push_back(model(inDataWord, inAmount, inDir));
                if (outputValid) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (inDownReady) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output actual=%h required=none", outputData);
                        end else begin
                            check("scoreboard", outputData, exp_q.pop_front());
                        end
                        pop_count++;
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) check("stall_hold", outputData, held);
                        held = outputData;
                        prev_stall = 1'b1;
                    end
                end else begin
                    run_len = 0;
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge inClk);
        #1;
    endtask

    task automatic send(input logic [L*W-1:0] d, input logic [L*S-1:0] a, input logic [L-1:0] r);
        int guard;
        inValid = 1'b1;
        inDataWord = d;
        inAmount = a;
        inDir = r;
        guard = 0;
        @(negedge inClk);
        while (!outputUpReady && guard < 50) begin
            @(negedge inClk);
            guard++;
        end
        if (!outputUpReady) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
        step();
        inValid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!outputValid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            step();
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input string name, input logic [L*W-1:0] d, input logic [L*S-1:0] a,
                            input logic [L-1:0] r, input logic [L*W-1:0] req);
        int lat;
        send(d, a, r);
        wait_out(lat);
        check({name, "_latency"}, lat, S - 1);
        check({name, "_data"}, outputData, req);
        step();
        check({name, "_one_cycle"}, outputValid, 1'b0);
    endtask

    initial begin
        int acc, lat, stale, pops0;
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, lat, stale, pops0;
        inRst = 1'b1;
        inValid = 1'b0;
        inDataWord = '0;
        inAmount = '0;
        inDir = '0;
        inDownReady = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_amount = 3'd0;
        s_dir = 1'b0;
        s_down_ready = 1'b1;
        step();
        step();
        check("reset_valid", outputValid, 1'b0);
        check("reset_data", outputData, '0);
        inRst = 1'b0;
        step();
        check("reset_up_ready", outputUpReady, 1'b1);

        directed("rotl8", {96'h0, 32'h00800080}, {15'd0, 5'd8}, 4'b0000, {96'h0, 32'h80008000});
        directed("mixed", {4{32'h12345678}}, {5'd0, 5'd5, 5'd8, 5'd8}, 4'b0010,
                 {32'h12345678, 32'h468ACF02, 32'h78123456, 32'h34567812});
        directed("edge1", {4{32'h80000001}}, {5'd31, 5'd31, 5'd1, 5'd1}, 4'b1010,
                 {32'h00000003, 32'hC0000000, 32'hC0000000, 32'h00000003});

        // back-to-back burst of 10 with no backpressure
        drain();
        max_run = 0;
        pops0 = pop_count;
        for (int i = 0; i < 10; i++) send(rnd_data(), rnd_amt(), 4'($urandom));
        drain();
        check("burst_run", max_run, 10);
        check("burst_count", pop_count - pops0, 10);

        // fill under backpressure
        inDownReady = 1'b0;
        acc = 0;
        for (int g = 0; g < 20; g++) begin
            inValid = 1'b1;
            inDataWord = rnd_data();
            inAmount = rnd_amt();
            inDir = 4'($urandom);
            @(negedge inClk);
            if (!outputUpReady) break;
            acc++;
            step();
        end
        check("stall_accepts", acc, S);
        repeat (3) step();
        check("stalled_ready", outputUpReady, 1'b0);
        inDownReady = 1'b1;
        @(negedge inClk);
        check("full_pass_ready", outputUpReady, 1'b1);
        step();
        inValid = 1'b0;
        drain();

        // random valid/ready traffic
        for (int c = 0; c < 300; c++) begin
            inValid = 1'($urandom);
            inDataWord = rnd_data();
            inAmount = rnd_amt();
            inDir = 4'($urandom);
            inDownReady = ($urandom % 4) != 0;
            step();
        end
        inValid = 1'b0;
        inDownReady = 1'b1;
        drain();

        // reset with beats in flight
        for (int i = 0; i < 7; i++) send(rnd_data() | 128'h1, rnd_amt(), 4'($urandom));
        check("pre_reset_valid", outputValid, 1'b1);
        #2;
        inRst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_valid", outputValid, 1'b0);
        check("async_reset_data", outputData, '0);
        step();
        step();
        inRst = 1'b0;
        step();
        check("post_reset_ready", outputUpReady, 1'b1);
        stale = 0;
        repeat (10) begin
            if (outputValid) stale++;
            step();
        end
        check("no_stale_beat", stale, 0);

        // narrow instance: 8-bit single lane
        s_valid = 1'b1;
        s_data = 8'h81;
        s_amount = 3'd3;
        s_dir = 1'b0;
        @(negedge inClk);
        check("small_up_ready", s_up_ready, 1'b1);
        step();
        s_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("small_latency", lat, 2);
        check("small_data", s_out_data, 8'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
